// File: rtl/uart_pkg.sv
// Shared UART definitions: frame state encoding, default frame shape and parity helper.
// Imported by both the transmitter and the receiver so their framing always agrees.
package uart_pkg;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'b000,
      ST_START  = 3'b001,
      ST_DATA   = 3'b010,
      ST_PARITY = 3'b100,
      ST_STOP   = 3'b011
   } uart_state_t;

   localparam int UART_DATA_BITS = 8;
   localparam int UART_STOP_BITS = 1;

   // Payloads narrower than 8 bits are zero-extended, which leaves the XOR unchanged.
   function automatic logic uart_parity(input logic [7:0] data, input logic odd);
      return (^data) ^ odd;
   endfunction

endpackage

// File: rtl/uart_tx.sv
// UART transmitter: start bit, DATA_BITS LSB first, optional parity, STOP_BITS stop bits.
// Bit timing from the external pulse_tx tick; one frame at a time, tx_start ignored while busy.
module uart_tx
   import uart_pkg::*;
#(
   parameter int DATA_BITS  = UART_DATA_BITS,
   parameter int PARITY_EN  = 0,
   parameter int PARITY_ODD = 0,
   parameter int STOP_BITS  = UART_STOP_BITS
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 pulse_tx,
   input  logic                 tx_start,
   input  logic [DATA_BITS-1:0] tx_data,
   output logic                 tx,
   output logic                 tx_busy,
   output logic                 tx_done
);

   localparam int CW = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;

   uart_state_t          r_state;
   logic [CW-1:0]        r_cnt;
   logic [DATA_BITS-1:0] r_shift;
   logic                 r_par;
   logic                 r_pending;
   logic                 r_stop_cnt;
   logic                 r_tx;
   logic                 r_busy;
   logic                 r_done;
   logic [7:0]           w_data_ext;

   always_comb begin
      w_data_ext                = '0;
      w_data_ext[DATA_BITS-1:0] = tx_data;
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         r_state    <= ST_IDLE;
         r_cnt      <= '0;
         r_shift    <= '0;
         r_par      <= 1'b0;
         r_pending  <= 1'b0;
         r_stop_cnt <= 1'b0;
         r_tx       <= 1'b1;
         r_busy     <= 1'b0;
         r_done     <= 1'b0;
      end else begin
         r_done <= 1'b0;
         case (r_state)
            ST_IDLE: begin
               r_tx <= 1'b1;
               // pending is still 0 on the acceptance edge, so a tick there cannot start a short start bit
               if (r_pending && pulse_tx) begin
                  r_state <= ST_START;
                  r_tx    <= 1'b0;
               end
            end
            ST_START: begin
               if (pulse_tx) begin
                  r_state <= ST_DATA;
                  r_tx    <= r_shift[0];
                  r_cnt   <= '0;
               end
            end
            ST_DATA: begin
               if (pulse_tx) begin
                  if (r_cnt == CW'(DATA_BITS - 1)) begin
                     if (PARITY_EN != 0) begin
                        r_state <= ST_PARITY;
                        r_tx    <= r_par;
                     end else begin
                        r_state    <= ST_STOP;
                        r_tx       <= 1'b1;
                        r_stop_cnt <= 1'b0;
                     end
                  end else begin
                     r_shift <= r_shift >> 1;
                     r_tx    <= r_shift[1];
                     r_cnt   <= r_cnt + 1'b1;
                  end
               end
            end
            ST_PARITY: begin
               if (pulse_tx) begin
                  r_state    <= ST_STOP;
                  r_tx       <= 1'b1;
                  r_stop_cnt <= 1'b0;
               end
            end
            ST_STOP: begin
               r_tx <= 1'b1;
               if (pulse_tx) begin
                  if (r_stop_cnt == 1'(STOP_BITS - 1)) begin
                     r_state   <= ST_IDLE;
                     r_pending <= 1'b0;
                     r_busy    <= 1'b0;
                     r_done    <= 1'b1;
                  end else begin
                     r_stop_cnt <= 1'b1;
                  end
               end
            end
            default: begin
               r_state   <= ST_IDLE;
               r_tx      <= 1'b1;
               r_busy    <= 1'b0;
               r_pending <= 1'b0;
            end
         endcase

         // Parity is taken from the whole byte at capture time, not from the shifting copy.
         if (tx_start && !r_busy) begin
            r_shift   <= tx_data;
            r_par     <= uart_parity(w_data_ext, 1'(PARITY_ODD));
            r_pending <= 1'b1;
            r_busy    <= 1'b1;
         end
      end
   end

   assign tx      = r_tx;
   assign tx_busy = r_busy;
   assign tx_done = r_done;

endmodule

// File: tb/tb_uart_tx.sv
// Directed bench for uart_tx: three instances (8N1, 8E1, 8O2) share clock, reset and baud tick;
// expected frames are queued at acceptance and compared as the serial line is decoded.
module tb_uart_tx;

   localparam int BAUD = 6;

   typedef struct {
      int          dut;
      logic [15:0] bits;
      int          n;
      logic [7:0]  data;
   } exp_t;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       pulse_tx = 1'b0;
   logic [2:0] tx_start = 3'b000;
   logic [7:0] tx_data = 8'h00;
   logic [2:0] tx_v, busy_v, done_v;

   int   n_cmp = 0;
   int   n_err = 0;
   int   pcnt = 0;
   exp_t sb[$];

   bit cfg_pen [3] = '{1'b0, 1'b1, 1'b1};
   bit cfg_odd [3] = '{1'b0, 1'b0, 1'b1};
   int cfg_stop[3] = '{1, 1, 2};

   uart_tx #(.DATA_BITS(8), .PARITY_EN(0), .PARITY_ODD(0), .STOP_BITS(1)) u_dut0 (
      .clk(clk), .rst(rst), .pulse_tx(pulse_tx), .tx_start(tx_start[0]), .tx_data(tx_data),
      .tx(tx_v[0]), .tx_busy(busy_v[0]), .tx_done(done_v[0]));
   uart_tx #(.DATA_BITS(8), .PARITY_EN(1), .PARITY_ODD(0), .STOP_BITS(1)) u_dut1 (
      .clk(clk), .rst(rst), .pulse_tx(pulse_tx), .tx_start(tx_start[1]), .tx_data(tx_data),
      .tx(tx_v[1]), .tx_busy(busy_v[1]), .tx_done(done_v[1]));
   uart_tx #(.DATA_BITS(8), .PARITY_EN(1), .PARITY_ODD(1), .STOP_BITS(2)) u_dut2 (
      .clk(clk), .rst(rst), .pulse_tx(pulse_tx), .tx_start(tx_start[2]), .tx_data(tx_data),
      .tx(tx_v[2]), .tx_busy(busy_v[2]), .tx_done(done_v[2]));

   always #5 clk = ~clk;

   // Baud tick: one cycle high every BAUD cycles, changed on the falling edge.
   initial begin
      forever begin
         @(negedge clk);
         pcnt     = (pcnt == BAUD - 1) ? 0 : pcnt + 1;
         pulse_tx = (pcnt == 0);
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [15:0] mk_frame(input logic [7:0] d, input int dut, output int n);
      logic [15:0] f;
      int          ones;
      f    = '0;
      ones = 0;
      for (int i = 0; i < 8; i++) begin
         f[1+i] = d[i];
         ones += int'(d[i]);
      end
      n = 9;
      if (cfg_pen[dut]) begin
         f[n] = cfg_odd[dut] ? ((ones % 2) == 0) : ((ones % 2) == 1);
         n++;
      end
      for (int s = 0; s < cfg_stop[dut]; s++) begin
         f[n] = 1'b1;
         n++;
      end
      return f;
   endfunction

   // Positions the caller just after a falling edge whose following rising edge carries a tick.
   task automatic align_pulse();
      int c;
      c = 0;
      do begin
         @(negedge clk);
         #1;
         c++;
      end while (!pulse_tx && c < 20);
   endtask

   task automatic send(input int d, input logic [7:0] data, input bit push);
      exp_t e;
      int   n;
      tx_start[d] = 1'b1;
      tx_data     = data;
      @(posedge clk);
      #1;
      tx_start[d] = 1'b0;
      if (push) begin
         e.dut  = d;
         e.bits = mk_frame(data, d, n);
         e.n    = n;
         e.data = data;
         sb.push_back(e);
      end
   endtask

   task automatic capture(input int d, input int nbits, input int budget,
                          output logic [15:0] bits, output int lat, output int dones,
                          output int glitches, output bit done_ok, output bit timeout);
      int   c;
      logic prev, prev_busy;
      bits = '0; lat = 0; dones = 0; glitches = 0; done_ok = 1'b0; timeout = 1'b0;
      c = 0;
      do begin
         @(posedge clk);
         #1;
         c++;
         dones += int'(done_v[d]);
      end while (tx_v[d] !== 1'b0 && c < budget);
      if (tx_v[d] !== 1'b0) begin
         timeout = 1'b1;
         return;
      end
      lat = c;
      for (int k = 1; k <= nbits; k++) begin
         prev = tx_v[d];
         c    = 0;
         do begin
            prev_busy = busy_v[d];
            @(posedge clk);
            #1;
            c++;
            dones += int'(done_v[d]);
            if (!pulse_tx && tx_v[d] !== prev) glitches++;
         end while (!pulse_tx && c < budget);
         if (!pulse_tx) begin
            timeout = 1'b1;
            return;
         end
         if (k < nbits) bits[k] = tx_v[d];
         else done_ok = (done_v[d] === 1'b1) && (busy_v[d] === 1'b0) &&
                        (prev_busy === 1'b1) && (tx_v[d] === 1'b1);
      end
   endtask

   task automatic run_frame(input string tag, input int exp_lat);
      exp_t        e;
      logic [15:0] got;
      int          lat, dones, gl;
      bit          dok, to;
      if (sb.size() == 0) begin
         n_cmp++;
         n_err++;
         $error("FAIL %s/sb: observed empty queue expected a queued frame", tag);
         return;
      end
      e = sb.pop_front();
      capture(e.dut, e.n, 8 * BAUD, got, lat, dones, gl, dok, to);
      chk({tag, "/timeout"}, 32'(to), 32'd0);
      chk({tag, "/bits"}, 32'(got), 32'(e.bits));
      chk({tag, "/rx_data"}, 32'(got[8:1]), 32'(e.data));
      if (exp_lat >= 0) chk({tag, "/latency"}, 32'(lat), 32'(exp_lat));
      chk({tag, "/done_cnt"}, 32'(dones), 32'd1);
      chk({tag, "/glitch"}, 32'(gl), 32'd0);
      chk({tag, "/done_busy"}, 32'(dok), 32'd1);
   endtask

   task automatic watch_idle(input string tag, input int cycles);
      int bad;
      bad = 0;
      for (int i = 0; i < cycles; i++) begin
         @(posedge clk);
         #1;
         if (tx_v !== 3'b111 || busy_v !== 3'b000 || done_v !== 3'b000) bad++;
      end
      chk(tag, 32'(bad), 32'd0);
   endtask

   initial begin
      int c;
      // Reset held for three edges.
      rst = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk("rst/tx", 32'(tx_v), 32'h7);
      chk("rst/busy", 32'(busy_v), 32'h0);
      chk("rst/done", 32'(done_v), 32'h0);
      rst = 1'b1;
      watch_idle("post_rst/idle", 15);

      // 8N1 0x55, accepted on a tick edge: start bit waits a full baud period.
      align_pulse();
      send(0, 8'h55, 1'b1);
      chk("f55/busy_after_accept", 32'(busy_v[0]), 32'd1);
      run_frame("f55", BAUD);
      @(posedge clk);
      #1;
      chk("f55/done_one_cycle", 32'(done_v[0]), 32'd0);

      // Even and odd parity on 0xA5 (odd instance also has two stop bits).
      align_pulse();
      send(1, 8'hA5, 1'b1);
      run_frame("fA5_even", BAUD);
      align_pulse();
      send(2, 8'hA5, 1'b1);
      run_frame("fA5_odd", BAUD);

      // Second request while busy is dropped.
      align_pulse();
      send(0, 8'h3C, 1'b1);
      @(posedge clk);
      #1;
      send(0, 8'hFF, 1'b0);
      run_frame("f3C", -1);
      watch_idle("f3C/no_second_frame", 4 * BAUD);

      // Back-to-back: next request issued in the tx_done cycle.
      align_pulse();
      send(0, 8'h42, 1'b1);
      run_frame("f42", BAUD);
      chk("b2b/done_at_request", 32'(done_v[0]), 32'd1);
      send(0, 8'h81, 1'b1);
      run_frame("f81_b2b", BAUD - 1);

      // Reset during data bit 3 of 0x0F aborts the frame.
      align_pulse();
      send(0, 8'h0F, 1'b0);
      c = 0;
      for (int seen = 0; seen < 5 && c < 12 * BAUD; ) begin
         @(posedge clk);
         #1;
         c++;
         if (pulse_tx) seen++;
      end
      chk("abort/busy_before", 32'(busy_v[0]), 32'd1);
      rst = 1'b0;
      @(posedge clk);
      #1;
      chk("abort/tx", 32'(tx_v[0]), 32'd1);
      chk("abort/busy", 32'(busy_v[0]), 32'd0);
      chk("abort/done", 32'(done_v[0]), 32'd0);
      rst = 1'b1;
      watch_idle("abort/quiet", 14 * BAUD);
      align_pulse();
      send(0, 8'h0F, 1'b1);
      run_frame("f0F_clean", BAUD);

      chk("sb/drained", 32'(sb.size()), 32'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
